mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-RAM port between instruction fetch (IF) and the load/store path (MEM).
//  Each requester uses a req/ready handshake; the arbiter registers the granted request and drives
//  the RAM port until ram_ack, then returns one response pulse to the owner.
//  A watchdog bounds every RAM transaction. Sits between fetch/mem stages and the RAM model.
// PARAMETERS
//  ADDR_W   64   address width
//  DATA_W   64   data width; byte mask is DATA_W/8
//  TIMEOUT  256  max cycles waiting for ram_ack before error response (>=2)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  if_req     in   1        fetch read request, held until if_ready
//  if_addr    in   ADDR_W   fetch address
//  if_ready   out  1        request accepted this cycle
//  if_rvalid  out  1        one-cycle response pulse
//  if_rdata   out  DATA_W   read data, valid with if_rvalid
//  if_err     out  1        timeout error, valid with if_rvalid
//  mem_req    in   1        load/store request, held until mem_ready
//  mem_we     in   1        1 = store, 0 = load
//  mem_addr   in   ADDR_W   load/store address
//  mem_wdata  in   DATA_W   store data
//  mem_wmask  in   DATA_W/8 store byte enables
//  mem_ready  out  1        request accepted this cycle
//  mem_rvalid out  1        one-cycle response pulse (loads and stores)
//  mem_rdata  out  DATA_W   load data; 0 for stores
//  mem_err    out  1        timeout error, valid with mem_rvalid
//  ram_req    out  1        RAM transaction active
//  ram_we     out  1        RAM write
//  ram_addr   out  ADDR_W   RAM address
//  ram_wdata  out  DATA_W   RAM write data
//  ram_wmask  out  DATA_W/8 RAM byte enables; 0 on reads
//  ram_ack    in   1        RAM done this cycle; ram_rdata valid
//  ram_rdata  in   DATA_W   RAM read data
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, watchdog 0, last_grant=IF. ram_ack ignored while rst=1.
//  - States: IDLE, BUSY.
//  - IDLE: no req -> stay. Any req -> grant one; its *_ready=1 (combinational, IDLE only);
//    latch owner, we, addr, wdata, wmask (IF: we=0, wmask=0); next state BUSY.
//  - Tie (both req in IDLE): fixed priority, MEM wins (older instruction; avoids deadlock).
//  - BUSY: ram_req=1; ram_* driven from latched regs, stable until ack. Both *_ready=0.
//    Watchdog increments each BUSY cycle.
//  - ram_ack in BUSY: next cycle owner *_rvalid=1 for one cycle, *_rdata=registered ram_rdata
//    (0 if we=1), *_err=0; state -> IDLE, watchdog cleared. Min latency ready -> rvalid = 2 cycles.
//  - Watchdog reaches TIMEOUT-1 without ack: next cycle owner rvalid=1, err=1, rdata=0;
//    state -> IDLE. ack in that same cycle wins (normal response, err=0).
//  - ram_ack outside BUSY: ignored, no response.
//  - rvalid cycle is an IDLE cycle: a new grant may be issued in it (back-to-back service).
//  - *_rdata/*_err hold their values between pulses; only *_rvalid is a pulse.
//  - Reset mid-transaction: ram_req drops at the next edge, pending response discarded,
//    no rvalid is produced.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: ties go to the requester not granted last; last_grant updates on
//   every grant. After reset, first tie goes to MEM.
//  MEM_ARB_RR_EN undefined: fixed MEM-over-IF priority; last_grant is absent.
//  Non-tie behaviour is identical in both builds.
// TESTING
//  1 IF read 0x80000000, ack after 3 BUSY cycles with rdata 0x1122334455667788
//    -> if_ready 1 cycle, ram_req 3 cycles, if_rvalid pulse with that data, if_err=0
//  2 MEM store addr 0x80001000, wdata 0xAB, wmask 0x01, ack 1 cycle later
//    -> ram_we=1, ram_wmask=0x01, mem_rvalid pulse, mem_rdata=0
//  3 Both req every cycle, ack 1 cycle each -> fixed: MEM served continuously, IF starves;
//    MEM_ARB_RR_EN: grants alternate MEM, IF, MEM, IF
//  4 IF read, no ack -> if_rvalid, if_err=1 exactly TIMEOUT cycles after grant; next grant accepted
//  5 rst for 1 cycle during BUSY -> ram_req=0 next cycle, no rvalid, late ram_ack ignored
//  6 stray ram_ack in IDLE with no req -> no rvalid; state stays IDLE

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch (IF) and load/store (MEM), with a per-transaction watchdog.
// Optional build macro MEM_ARB_RR_EN: ties alternate between requesters instead of fixed MEM-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_ready,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wmask,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata
);
  localparam int MASK_W = DATA_W / 8;
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                mem_rvalid_q, mem_rvalid_d, mem_err_q, mem_err_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                grant_if, grant_mem, mem_wins, timeout_hit;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_err;
`ifdef MEM_ARB_RR_EN
  logic                last_grant_q, last_grant_d;
`endif

  // Grant selection: only in IDLE and never while reset is asserted.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    mem_wins = (last_grant_q == OWN_IF);
`else
    mem_wins = 1'b1;
`endif
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (!rst && state_q == IDLE) begin
      grant_mem = mem_req && (!if_req || mem_wins);
      grant_if  = if_req && !grant_mem;
    end else begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
    end
  end

  // Next-state, request latching, watchdog and response generation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wdog_d       = wdog_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    if_err_d     = if_err_q;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    mem_err_d    = mem_err_q;
    timeout_hit  = (wdog_q == WD_W'(TIMEOUT - 1));
    resp_data    = '0;
    resp_err     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (grant_mem) begin
          state_d = BUSY;
          owner_d = OWN_MEM;
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wmask_d = mem_we ? mem_wmask : '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = OWN_MEM;
`endif
        end else if (grant_if) begin
          state_d = BUSY;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          wmask_d = '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = OWN_IF;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + WD_W'(1);
        // An ack in the final watchdog cycle still counts as a normal completion.
        if (ram_ack || timeout_hit) begin
          state_d   = IDLE;
          wdog_d    = '0;
          resp_data = (ram_ack && !we_q) ? ram_rdata : '0;
          resp_err  = !ram_ack;
          if (owner_q == OWN_MEM) begin
            mem_rvalid_d = 1'b1;
            mem_rdata_d  = resp_data;
            mem_err_d    = resp_err;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp_data;
            if_err_d    = resp_err;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wdog_q       <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      mem_err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_IF;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wdog_q       <= wdog_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_err_q    <= mem_err_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_ready   = grant_if;
  assign mem_ready  = grant_mem;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign if_err     = if_err_q;
  assign mem_rvalid = mem_rvalid_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_err    = mem_err_q;
  assign ram_req    = (state_q == BUSY);
  assign ram_we     = (state_q == BUSY) && we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_wmask  = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT shortened to 8).
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready, if_rvalid, if_err;
  logic [63:0] if_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready, mem_rvalid, mem_err;
  logic [63:0] mem_rdata;
  logic        ram_req, ram_we, ram_ack;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  ram_wmask;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int busy_cycles;
    int n;
    logic exp_mem;
    rst = 1'b1; if_req = 1'b0; if_addr = 64'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = 64'h0; mem_wdata = 64'h0; mem_wmask = 8'h00; ram_ack = 1'b0; ram_rdata = 64'h0;

    // Reset: outputs quiet, no grant even with a request pending
    step(); step();
    if_req = 1'b1; ram_ack = 1'b1;
    #1;
    check_eq("rst_if_ready", 64'(if_ready), 64'd0);
    check_eq("rst_ram_req", 64'(ram_req), 64'd0);
    check_eq("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("rst_mem_rvalid", 64'(mem_rvalid), 64'd0);
    check_eq("rst_ram_addr", ram_addr, 64'd0);
    if_req = 1'b0; ram_ack = 1'b0;
    step();
    rst = 1'b0;
    step();

    // 1: IF read, ack in third BUSY cycle
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0000;
    #1;
    check_eq("t1_if_ready", 64'(if_ready), 64'd1);
    check_eq("t1_mem_ready", 64'(mem_ready), 64'd0);
    step();
    if_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      busy_cycles += int'(ram_req);
      if (i == 0) begin
        check_eq("t1_ram_addr", ram_addr, 64'h0000_0000_8000_0000);
        check_eq("t1_ram_we", 64'(ram_we), 64'd0);
        check_eq("t1_ram_wmask", 64'(ram_wmask), 64'd0);
        check_eq("t1_if_ready_busy", 64'(if_ready), 64'd0);
      end
      if (i == 2) begin
        ram_ack = 1'b1; ram_rdata = 64'h1122_3344_5566_7788;
      end
      step();
    end
    ram_ack = 1'b0;
    check_eq("t1_busy_cycles", 64'(busy_cycles), 64'd3);
    check_eq("t1_ram_req_after", 64'(ram_req), 64'd0);
    check_eq("t1_if_rvalid", 64'(if_rvalid), 64'd1);
    check_eq("t1_if_rdata", if_rdata, 64'h1122_3344_5566_7788);
    check_eq("t1_if_err", 64'(if_err), 64'd0);
    step();
    check_eq("t1_rvalid_pulse", 64'(if_rvalid), 64'd0);
    check_eq("t1_rdata_hold", if_rdata, 64'h1122_3344_5566_7788);

    // 2: MEM store, ack in first BUSY cycle
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h0000_0000_8000_1000;
    mem_wdata = 64'h0000_0000_0000_00AB; mem_wmask = 8'h01;
    #1;
    check_eq("t2_mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_req = 1'b0; mem_we = 1'b0;
    check_eq("t2_ram_we", 64'(ram_we), 64'd1);
    check_eq("t2_ram_wmask", 64'(ram_wmask), 64'h01);
    check_eq("t2_ram_wdata", ram_wdata, 64'h0000_0000_0000_00AB);
    check_eq("t2_ram_addr", ram_addr, 64'h0000_0000_8000_1000);
    ram_ack = 1'b1; ram_rdata = 64'hDEAD_BEEF_0000_0000;
    step();
    ram_ack = 1'b0;
    check_eq("t2_mem_rvalid", 64'(mem_rvalid), 64'd1);
    check_eq("t2_mem_rdata", mem_rdata, 64'd0);
    check_eq("t2_mem_err", 64'(mem_err), 64'd0);
    check_eq("t2_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("t2_if_rdata_hold", if_rdata, 64'h1122_3344_5566_7788);
    step();

    // 3: both requesting continuously, fresh reset so the first tie goes to MEM
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    if_req = 1'b1; if_addr = 64'h100; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h200;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_mem = (i % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      check_eq($sformatf("t3_mem_ready_%0d", i), 64'(mem_ready), 64'(exp_mem));
      check_eq($sformatf("t3_if_ready_%0d", i), 64'(if_ready), 64'(!exp_mem));
      step();
      check_eq($sformatf("t3_ram_addr_%0d", i), ram_addr, exp_mem ? 64'h200 : 64'h100);
      ram_ack = 1'b1; ram_rdata = 64'(i + 16);
      step();
      ram_ack = 1'b0;
      check_eq($sformatf("t3_rvalid_%0d", i), 64'(exp_mem ? mem_rvalid : if_rvalid), 64'd1);
      check_eq($sformatf("t3_rdata_%0d", i), exp_mem ? mem_rdata : if_rdata, 64'(i + 16));
      if (i == 3) begin
        if_req = 1'b0; mem_req = 1'b0;
      end
      #1;
    end
    step();

    // 4: IF read with no ack -> error response after TO BUSY cycles, then MEM grant in rvalid cycle
    if_req = 1'b1; if_addr = 64'h300;
    #1;
    check_eq("t4_if_ready", 64'(if_ready), 64'd1);
    step();
    if_req = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!if_rvalid && n < 40) begin
      busy_cycles += int'(ram_req);
      step();
      n++;
    end
    check_eq("t4_if_rvalid", 64'(if_rvalid), 64'd1);
    check_eq("t4_busy_cycles", 64'(busy_cycles), 64'(TO));
    check_eq("t4_if_err", 64'(if_err), 64'd1);
    check_eq("t4_if_rdata", if_rdata, 64'd0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h400;
    #1;
    check_eq("t4_next_mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_req = 1'b0;
    ram_ack = 1'b1; ram_rdata = 64'h55;
    step();
    ram_ack = 1'b0;
    check_eq("t4_mem_rvalid", 64'(mem_rvalid), 64'd1);
    check_eq("t4_mem_rdata", mem_rdata, 64'h55);
    check_eq("t4_if_err_hold", 64'(if_err), 64'd1);
    step();

    // 4b: ack in the last watchdog cycle wins over the timeout
    if_req = 1'b1; if_addr = 64'h500;
    step();
    if_req = 1'b0;
    for (int i = 0; i < TO - 1; i++) step();
    check_eq("t4b_ram_req_last", 64'(ram_req), 64'd1);
    check_eq("t4b_no_early_rvalid", 64'(if_rvalid), 64'd0);
    ram_ack = 1'b1; ram_rdata = 64'hCAFE;
    step();
    ram_ack = 1'b0;
    check_eq("t4b_if_rvalid", 64'(if_rvalid), 64'd1);
    check_eq("t4b_if_err", 64'(if_err), 64'd0);
    check_eq("t4b_if_rdata", if_rdata, 64'hCAFE);
    step();

    // 5: reset during BUSY discards the transaction
    if_req = 1'b1; if_addr = 64'h600;
    step();
    if_req = 1'b0;
    check_eq("t5_busy", 64'(ram_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_ram_req_dropped", 64'(ram_req), 64'd0);
    check_eq("t5_no_rvalid", 64'(if_rvalid), 64'd0);
    ram_ack = 1'b1; ram_rdata = 64'h77;
    step();
    ram_ack = 1'b0;
    check_eq("t5_late_ack_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("t5_late_ack_ram_req", 64'(ram_req), 64'd0);

    // 6: stray ack in IDLE is ignored
    ram_ack = 1'b1; ram_rdata = 64'h99;
    step();
    ram_ack = 1'b0;
    check_eq("t6_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("t6_mem_rvalid", 64'(mem_rvalid), 64'd0);
    check_eq("t6_ram_req", 64'(ram_req), 64'd0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h700;
    #1;
    check_eq("t6_still_idle", 64'(mem_ready), 64'd1);
    step();
    mem_req = 1'b0;
    ram_ack = 1'b1; ram_rdata = 64'h1234;
    step();
    ram_ack = 1'b0;
    check_eq("t6_mem_rdata", mem_rdata, 64'h1234);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
